// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Shared encodings for the car controller:
//   - driving-mode codes (mode_sel / global_state)
//   - motion codes sent to the motor driver
//   - semi-auto FSM state codes
//   - mode-controller FSM state type
// Helper functions:
//   - mode_valid  : 1 for the three real modes, 0 for the reserved 11 code
//   - select_move : picks the motion code belonging to a given mode
// -----------------------------------------------------------------------------
package car_pkg;

    // Width shared by the press, debounce and settle counters.
    localparam int CNT_W = 11;

    // Driving modes
    localparam logic [1:0] MODE_MANUAL  = 2'b00;
    localparam logic [1:0] MODE_SEMI    = 2'b01;
    localparam logic [1:0] MODE_AUTO    = 2'b10;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    // Motion codes
    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    // Semi-auto FSM states
    localparam logic [1:0] SEMI_FWD  = 2'b00;
    localparam logic [1:0] SEMI_WAIT = 2'b01;
    localparam logic [1:0] SEMI_TURN = 2'b10;
    localparam logic [1:0] SEMI_COOL = 2'b11;

    // Mode-controller FSM states
    typedef enum logic [1:0] {
        OFF    = 2'b00,
        RUN    = 2'b01,
        SWITCH = 2'b10
    } ctrl_state_t;

    function automatic logic mode_valid(input logic [1:0] mode);
        return (mode != MODE_INVALID);
    endfunction

    function automatic logic [3:0] select_move(
        input logic [1:0] mode,
        input logic [3:0] manual_mv,
        input logic [3:0] semi_mv,
        input logic [3:0] auto_mv
    );
        logic [3:0] mv;
        case (mode)
            MODE_MANUAL: mv = manual_mv;
            MODE_SEMI:   mv = semi_mv;
            MODE_AUTO:   mv = auto_mv;
            default:     mv = MV_STOP;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// -----------------------------------------------------------------------------
// ms_tick
// Free-running prescaler producing a single-cycle pulse every MS_DIV cycles.
// Ports:
//   sys_clk : system clock
//   rst     : synchronous active-high reset (clears the prescaler)
//   tick    : registered 1-cycle pulse, once per MS_DIV cycles
// -----------------------------------------------------------------------------
module ms_tick #(
    parameter int MS_DIV = 100000
) (
    input  logic sys_clk,
    input  logic rst,
    output logic tick
);

    // Keep at least one bit so a divide-by-one build still elaborates.
    localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(MS_DIV - 1);

    logic [CW-1:0] div_cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            tick        <= 1'b0;
        end else if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            tick        <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
            tick        <= 1'b0;
        end
    end

endmodule

// File: rtl/drive_mode_ctrl.sv
// -----------------------------------------------------------------------------
// drive_mode_ctrl
// Top-level mode controller: long-press power toggle, debounced mode
// selection, semi-auto state register and motion-code arbitration with a
// forced stop-and-settle interval on every mode change.
// Parameters:
//   MS_DIV    : sys_clk cycles per 1 ms tick
//   PWR_MS    : button hold time (ticks) that toggles power
//   DEB_MS    : ticks mode_sel must be stable before acceptance
//   SETTLE_MS : stop interval (ticks) on a mode change
// Ports:
//   sys_clk, rst          : clock, synchronous active-high reset
//   power_btn, mode_sel   : raw asynchronous button / mode switches
//   manual_move, semi_move, auto_move : per-mode motion codes
//   semi_next_state       : next state from the semi-auto FSM
//   power                 : vehicle powered
//   global_state          : committed mode
//   semi_state            : registered semi-auto state
//   moving_state          : motion code to the motors
//   mode_changing         : high while settling into a new mode
// -----------------------------------------------------------------------------
module drive_mode_ctrl
    import car_pkg::*;
#(
    parameter int MS_DIV    = 100000,
    parameter int PWR_MS    = 1000,
    parameter int DEB_MS    = 20,
    parameter int SETTLE_MS = 200
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic [1:0] mode_sel,
    input  logic [3:0] manual_move,
    input  logic [1:0] semi_next_state,
    input  logic [3:0] semi_move,
    input  logic [3:0] auto_move,
    output logic       power,
    output logic [1:0] global_state,
    output logic [1:0] semi_state,
    output logic [3:0] moving_state,
    output logic       mode_changing
);

    localparam logic [CNT_W-1:0] PWR_LIM    = CNT_W'(PWR_MS);
    localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEB_MS);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_MS);

    // ------------------------------------------------------------------
    // 2-flop synchronisers: bit 2 = power_btn, bits 1:0 = mode_sel
    // ------------------------------------------------------------------
    logic [2:0] async_in;
    logic [2:0] sync_out;

    assign async_in = {power_btn, mode_sel};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_out[gi] = sync_reg;
        end
    endgenerate

    logic       btn_sync;
    logic [1:0] mode_sync;

    assign btn_sync  = sync_out[2];
    assign mode_sync = sync_out[1:0];

    // ------------------------------------------------------------------
    // 1 ms tick
    // ------------------------------------------------------------------
    logic tick;

    ms_tick #(
        .MS_DIV (MS_DIV)
    ) u_ms_tick (
        .sys_clk (sys_clk),
        .rst     (rst),
        .tick    (tick)
    );

    // ------------------------------------------------------------------
    // Press counter and power toggle
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] press_cnt_reg;
    logic             toggle;

    always_ff @(posedge sys_clk) begin
        if (rst || !btn_sync) begin
            press_cnt_reg <= '0;
        end else if (tick && (press_cnt_reg < PWR_LIM)) begin
            press_cnt_reg <= press_cnt_reg + 1'b1;
        end
    end

    // Fires only on the tick that carries the count onto PWR_LIM; once
    // saturated the counter must be cleared by a release to fire again.
    assign toggle = btn_sync && tick && (press_cnt_reg == (PWR_LIM - 1'b1));

    // ------------------------------------------------------------------
    // Mode-select debounce
    // ------------------------------------------------------------------
    logic [1:0]       deb_val_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic [1:0]       mode_req_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            deb_val_reg  <= MODE_MANUAL;
            deb_cnt_reg  <= '0;
            mode_req_reg <= MODE_MANUAL;
        end else if (mode_sync != deb_val_reg) begin
            // Any movement of the switches restarts the stability window.
            deb_val_reg <= mode_sync;
            deb_cnt_reg <= '0;
        end else if (tick && (deb_cnt_reg < DEB_LIM)) begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
            if ((deb_cnt_reg + 1'b1) == DEB_LIM) begin
                mode_req_reg <= deb_val_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM with registered outputs
    // ------------------------------------------------------------------
    ctrl_state_t      state_reg;
    logic [1:0]       target_reg;
    logic [CNT_W-1:0] settle_cnt_reg;

    logic             req_valid;
    logic [1:0]       start_mode;
    logic [3:0]       start_move;
    logic [3:0]       run_move;
    logic [3:0]       target_move;
    logic             semi_tracking;

    assign req_valid     = mode_valid(mode_req_reg);
    // Powering up on the reserved code falls back to manual.
    assign start_mode    = req_valid ? mode_req_reg : MODE_MANUAL;
    assign start_move    = select_move(start_mode, manual_move, semi_move, auto_move);
    assign run_move      = select_move(global_state, manual_move, semi_move, auto_move);
    assign target_move   = select_move(target_reg, manual_move, semi_move, auto_move);
    assign semi_tracking = (state_reg == RUN) &&
                           ((global_state == MODE_SEMI) || (global_state == MODE_AUTO));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg      <= OFF;
            power          <= 1'b0;
            global_state   <= MODE_MANUAL;
            target_reg     <= MODE_MANUAL;
            settle_cnt_reg <= '0;
            mode_changing  <= 1'b0;
            moving_state   <= MV_STOP;
            semi_state     <= SEMI_WAIT;
        end else begin
            // Semi-auto state register: the external FSM's next state is fed
            // back only while one of the autonomous modes is actually running.
            semi_state <= semi_tracking ? semi_next_state : SEMI_WAIT;

            case (state_reg)
                OFF: begin
                    power         <= 1'b0;
                    global_state  <= MODE_MANUAL;
                    mode_changing <= 1'b0;
                    moving_state  <= MV_STOP;
                    if (toggle) begin
                        state_reg    <= RUN;
                        power        <= 1'b1;
                        global_state <= start_mode;
                        moving_state <= start_move;
                    end
                end

                RUN: begin
                    if (toggle) begin
                        state_reg     <= OFF;
                        power         <= 1'b0;
                        global_state  <= MODE_MANUAL;
                        mode_changing <= 1'b0;
                        moving_state  <= MV_STOP;
                    end else if (req_valid && (mode_req_reg != global_state)) begin
                        state_reg      <= SWITCH;
                        target_reg     <= mode_req_reg;
                        settle_cnt_reg <= '0;
                        mode_changing  <= 1'b1;
                        moving_state   <= MV_STOP;
                    end else begin
                        moving_state <= run_move;
                    end
                end

                SWITCH: begin
                    if (toggle) begin
                        state_reg     <= OFF;
                        power         <= 1'b0;
                        global_state  <= MODE_MANUAL;
                        mode_changing <= 1'b0;
                        moving_state  <= MV_STOP;
                    end else if (mode_req_reg == global_state) begin
                        // Request withdrawn: resume the old mode, nothing committed.
                        state_reg     <= RUN;
                        mode_changing <= 1'b0;
                        moving_state  <= run_move;
                    end else if (req_valid && (mode_req_reg != target_reg)) begin
                        target_reg     <= mode_req_reg;
                        settle_cnt_reg <= '0;
                        moving_state   <= MV_STOP;
                    end else if (tick && (settle_cnt_reg < SETTLE_LIM)) begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        if ((settle_cnt_reg + 1'b1) == SETTLE_LIM) begin
                            state_reg     <= RUN;
                            global_state  <= target_reg;
                            mode_changing <= 1'b0;
                            moving_state  <= target_move;
                        end else begin
                            moving_state <= MV_STOP;
                        end
                    end else begin
                        moving_state <= MV_STOP;
                    end
                end

                default: begin
                    state_reg     <= OFF;
                    power         <= 1'b0;
                    global_state  <= MODE_MANUAL;
                    mode_changing <= 1'b0;
                    moving_state  <= MV_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_drive_mode_ctrl
// Directed scenarios followed by a randomized run. Every cycle the outputs are
// compared with a behavioural model built from the mode controller's rules
// (tick = every MS_DIV-th cycle, 2-cycle input delay, tick-counted stability
// and hold windows, mode bookkeeping), plus constant checks at scenario ends.
// -----------------------------------------------------------------------------
module tb_drive_mode_ctrl;

    localparam int MS_DIV    = 10;
    localparam int PWR_MS    = 5;
    localparam int DEB_MS    = 2;
    localparam int SETTLE_MS = 3;

    localparam int M_OFF = 0;
    localparam int M_RUN = 1;
    localparam int M_SW  = 2;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       power_btn = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic [3:0] manual_move = 4'h0;
    logic [1:0] semi_next_state = 2'b00;
    logic [3:0] semi_move = 4'h0;
    logic [3:0] auto_move = 4'h0;
    logic       power;
    logic [1:0] global_state;
    logic [1:0] semi_state;
    logic [3:0] moving_state;
    logic       mode_changing;

    drive_mode_ctrl #(
        .MS_DIV    (MS_DIV),
        .PWR_MS    (PWR_MS),
        .DEB_MS    (DEB_MS),
        .SETTLE_MS (SETTLE_MS)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .power_btn       (power_btn),
        .mode_sel        (mode_sel),
        .manual_move     (manual_move),
        .semi_next_state (semi_next_state),
        .semi_move       (semi_move),
        .auto_move       (auto_move),
        .power           (power),
        .global_state    (global_state),
        .semi_state      (semi_state),
        .moving_state    (moving_state),
        .mode_changing   (mode_changing)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    bit hold_moves = 1'b0;
    bit rand_semi  = 1'b0;
    bit saw_chg    = 1'b0;

    // ---------------- behavioural model ----------------
    int         m_cycles;       // clock edges since reset was released
    logic       m_pb_d1, m_pb_d2;
    logic [1:0] m_ms_d1, m_ms_d2;
    int         m_hold_ticks;
    logic [1:0] m_stable;
    int         m_stable_ticks;
    int         m_req;
    int         m_state;
    int         m_gs;
    int         m_target;
    int         m_settle;
    logic       m_power;
    logic       m_chg;
    logic [3:0] m_move;
    logic [1:0] m_semi;

    function automatic logic [3:0] mode_move(int mode);
        case (mode)
            0:       return manual_move;
            1:       return semi_move;
            2:       return auto_move;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_cycles = 0;
        m_pb_d1 = 0; m_pb_d2 = 0; m_ms_d1 = 0; m_ms_d2 = 0;
        m_hold_ticks = 0; m_stable = 0; m_stable_ticks = 0; m_req = 0;
        m_state = M_OFF; m_gs = 0; m_target = 0; m_settle = 0;
        m_power = 0; m_chg = 0; m_move = 4'h0; m_semi = 2'b01;
    endtask

    // Advances the model across one rising edge using the current inputs.
    task automatic model_edge();
        bit   tick;
        bit   toggle;
        int   prev_state;
        int   prev_gs;
        logic pb;
        logic [1:0] ms;
        if (rst) begin
            model_reset();
            return;
        end
        tick   = (m_cycles > 0) && (m_cycles % MS_DIV == 0);
        pb     = m_pb_d2;
        ms     = m_ms_d2;
        toggle = pb && tick && (m_hold_ticks == PWR_MS - 1);
        prev_state = m_state;
        prev_gs    = m_gs;

        case (m_state)
            M_OFF: begin
                if (toggle) begin
                    m_state = M_RUN;
                    m_gs = (m_req == 3) ? 0 : m_req;
                end
            end
            M_RUN: begin
                if (toggle) begin
                    m_state = M_OFF; m_gs = 0;
                end else if (m_req != 3 && m_req != m_gs) begin
                    m_target = m_req; m_settle = 0; m_state = M_SW;
                end
            end
            default: begin
                if (toggle) begin
                    m_state = M_OFF; m_gs = 0;
                end else if (m_req == m_gs) begin
                    m_state = M_RUN;
                end else if (m_req != 3 && m_req != m_target) begin
                    m_target = m_req; m_settle = 0;
                end else if (tick) begin
                    m_settle++;
                    if (m_settle == SETTLE_MS) begin
                        m_gs = m_target; m_state = M_RUN;
                    end
                end
            end
        endcase

        m_power = (m_state != M_OFF);
        m_chg   = (m_state == M_SW);
        m_move  = (m_state == M_RUN) ? mode_move(m_gs) : 4'h0;
        m_semi  = (prev_state == M_RUN && (prev_gs == 1 || prev_gs == 2)) ? semi_next_state : 2'b01;

        if (!pb) m_hold_ticks = 0;
        else if (tick && m_hold_ticks < PWR_MS) m_hold_ticks++;

        if (ms != m_stable) begin
            m_stable = ms; m_stable_ticks = 0;
        end else if (tick && m_stable_ticks < DEB_MS) begin
            m_stable_ticks++;
            if (m_stable_ticks == DEB_MS) m_req = int'(m_stable);
        end

        m_pb_d2 = m_pb_d1; m_pb_d1 = power_btn;
        m_ms_d2 = m_ms_d1; m_ms_d1 = mode_sel;
        m_cycles++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("power", 4'(power), 4'(m_power));
        check("global_state", 4'(global_state), 4'(m_gs));
        check("semi_state", 4'(semi_state), 4'(m_semi));
        check("moving_state", moving_state, m_move);
        check("mode_changing", 4'(mode_changing), 4'(m_chg));
    endtask

    task automatic step_cycle();
        if (!hold_moves) begin
            manual_move = 4'($urandom);
            semi_move   = 4'($urandom);
            auto_move   = 4'($urandom);
        end
        if (rand_semi) semi_next_state = 2'($urandom);
        model_edge();
        @(posedge sys_clk);
        @(negedge sys_clk);
        check_model();
        if (mode_changing) saw_chg = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic report(input string name);
        $display("step %-16s power=%0b global_state=%0b semi_state=%0b moving_state=%b mode_changing=%0b",
                 name, power, global_state, semi_state, moving_state, mode_changing);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int chg_cycles;
        int stop_bad;
        bit done;
        bit found;
        int pb_left;
        int ms_left;

        model_reset();
        @(negedge sys_clk);
        run(3);
        check("rst_power", 4'(power), 4'h0);
        check("rst_global_state", 4'(global_state), 4'h0);
        check("rst_semi_state", 4'(semi_state), 4'h1);
        check("rst_moving_state", moving_state, 4'h0);
        check("rst_mode_changing", 4'(mode_changing), 4'h0);
        report("reset");
        rst = 1'b0;

        // Power-on into semi-auto, keep holding, release.
        mode_sel = 2'b01;
        power_btn = 1'b1;
        run(60);
        check("pwr_on_power", 4'(power), 4'h1);
        check("pwr_on_mode", 4'(global_state), 4'h1);
        run(60);
        check("pwr_hold_no_retoggle", 4'(power), 4'h1);
        power_btn = 1'b0;
        run(5);
        report("power_on");

        // Semi-auto tracking.
        semi_next_state = 2'b00; step_cycle();
        check("semi_track_00", 4'(semi_state), 4'h0);
        semi_next_state = 2'b01; step_cycle();
        check("semi_track_01", 4'(semi_state), 4'h1);
        semi_next_state = 2'b10; step_cycle();
        check("semi_track_10", 4'(semi_state), 4'h2);
        mode_sel = 2'b00;
        run(70);
        check("to_manual_mode", 4'(global_state), 4'h0);
        check("to_manual_semi", 4'(semi_state), 4'h1);
        report("semi_tracking");

        // Glitch rejection: one-tick pulse, then the reserved code.
        saw_chg = 1'b0;
        mode_sel = 2'b01; run(10);
        mode_sel = 2'b00; run(40);
        mode_sel = 2'b11; run(60);
        check("glitch_no_switch", 4'(saw_chg), 4'h0);
        check("glitch_mode_kept", 4'(global_state), 4'h0);
        mode_sel = 2'b00; run(40);
        report("glitch");

        // Manual -> auto mode change.
        hold_moves = 1'b1;
        manual_move = 4'b0001; semi_move = 4'b1000; auto_move = 4'b0100;
        step_cycle();
        check("manual_fwd", moving_state, 4'b0001);
        mode_sel = 2'b10;
        chg_cycles = 0; stop_bad = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step_cycle();
            if (mode_changing) begin
                chg_cycles++;
                if (moving_state !== 4'h0) stop_bad++;
            end else if (chg_cycles > 0) begin
                done = 1'b1;
            end
        end
        check("switch_completed", 4'(done), 4'h1);
        check("switch_settle_len", 4'(chg_cycles >= 2 * MS_DIV + 1 && chg_cycles <= 3 * MS_DIV), 4'h1);
        check("switch_forced_stop", 4'(stop_bad), 4'h0);
        check("switch_commit_mode", 4'(global_state), 4'h2);
        check("switch_auto_move", moving_state, 4'b0100);
        auto_move = 4'b1000;
        step_cycle();
        check("auto_follow", moving_state, 4'b1000);
        hold_moves = 1'b0;
        report("mode_change");

        // Power-off from RUN.
        power_btn = 1'b1; run(60);
        check("pwr_off_power", 4'(power), 4'h0);
        check("pwr_off_moving", moving_state, 4'h0);
        check("pwr_off_mode", 4'(global_state), 4'h0);
        power_btn = 1'b0; run(5);
        report("power_off");

        // Power-off landing in the middle of SWITCH.
        power_btn = 1'b1; run(60);
        power_btn = 1'b0; run(5);
        check("repower_mode", 4'(global_state), 4'h2);
        power_btn = 1'b1;
        saw_chg = 1'b0;
        run(10);
        mode_sel = 2'b00;
        run(55);
        check("midswitch_entered", 4'(saw_chg), 4'h1);
        check("midswitch_power", 4'(power), 4'h0);
        check("midswitch_chg", 4'(mode_changing), 4'h0);
        check("midswitch_mode", 4'(global_state), 4'h0);
        power_btn = 1'b0; run(5);
        report("off_in_switch");

        // Reset in the middle of SWITCH.
        power_btn = 1'b1; run(60);
        power_btn = 1'b0; run(5);
        check("rst_test_powered", 4'(power), 4'h1);
        mode_sel = 2'b10;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step_cycle();
            if (mode_changing) found = 1'b1;
        end
        check("rst_test_in_switch", 4'(found), 4'h1);
        run(5);
        rst = 1'b1;
        step_cycle();
        check("midrst_power", 4'(power), 4'h0);
        check("midrst_global_state", 4'(global_state), 4'h0);
        check("midrst_semi_state", 4'(semi_state), 4'h1);
        check("midrst_moving_state", moving_state, 4'h0);
        check("midrst_mode_changing", 4'(mode_changing), 4'h0);
        rst = 1'b0;
        report("reset_in_switch");

        // Randomized run against the model.
        rand_semi = 1'b1;
        pb_left = 0; ms_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (pb_left == 0) begin
                power_btn = ($urandom_range(0, 2) == 0);
                pb_left = $urandom_range(1, 70);
            end
            if (ms_left == 0) begin
                mode_sel = 2'($urandom);
                ms_left = $urandom_range(1, 45);
            end
            rst = ($urandom_range(0, 499) == 0);
            pb_left--; ms_left--;
            step_cycle();
        end
        rst = 1'b0;
        report("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_mode_ctrl.md
# drive_mode_ctrl

Top-level mode controller for the car. It owns power on/off via a long-press button and selects manual, semi-auto or auto mode from debounced switches. It holds the semi-auto state register, feeding its next-state output back as the current state. It also arbitrates which mode's motion code reaches the motor driver, forcing a stop-and-settle interval on every mode change.

## Interface
- `MS_DIV`, 100000: `sys_clk` cycles per 1 ms tick.
- `PWR_MS`, 1000: button hold time, in ms, that toggles power.
- `DEB_MS`, 20: time, in ms, that `mode_sel` must be stable before it is accepted.
- `SETTLE_MS`, 200: stop interval, in ms, on a mode change.
- `sys_clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `power_btn`  in  1  raw power button, asynchronous.
- `mode_sel`  in  2  raw mode switches, asynchronous: 00 manual, 01 semi-auto, 10 auto, 11 invalid.
- `manual_move`  in  4  motion code from the manual controller.
- `semi_next_state`  in  2  next state from the semi-auto FSM.
- `semi_move`  in  4  motion code from the semi-auto FSM.
- `auto_move`  in  4  motion code from the auto FSM.
- `power`  out  1  vehicle powered.
- `global_state`  out  2  committed mode, same encoding as `mode_sel`.
- `semi_state`  out  2  registered semi-auto state: 00 forward, 01 waiting, 10 turning, 11 cooldown.
- `moving_state`  out  4  motion code to the motors: 0001 forward, 0000 stop, 0100 left, 1000 right.
- `mode_changing`  out  1  high while in SWITCH.

## Operation
- **Input synchronisation:** `power_btn` and `mode_sel` each pass through a 2-flop synchroniser.
- **Tick:** a 1 ms tick is a single-cycle pulse every `MS_DIV` cycles.
- **Debounce:** the synchronised `mode_sel` becomes `mode_req` after `DEB_MS` consecutive ticks with no change. Any change restarts the count.
- **Press counter:** counts ticks while the button is held and saturates at `PWR_MS`. It clears on release.
- **Power toggle:** when the count reaches `PWR_MS`, power toggles exactly once. Another toggle requires a release first.
- **FSM states:** OFF, RUN and SWITCH.
  - **OFF:**
    - `power` is 0, `global_state` is 00 and `moving_state` is 0000.
    - On a toggle, go to RUN with `global_state` = `mode_req`, or 00 if `mode_req` is 11.
  - **RUN:**
    - On a toggle, go to OFF.
    - Else, if `mode_req` is not 11 and differs from `global_state`, latch the target, clear the settle counter and go to SWITCH.
  - **SWITCH:**
    - `moving_state` is forced to 0000.
    - After `SETTLE_MS` ticks, commit `global_state` to the target and go to RUN.
    - A new valid, different `mode_req` replaces the target and restarts the settle count.
    - If `mode_req` returns to the current `global_state`, go to RUN without committing a change.
    - A toggle goes to OFF.
- **`semi_state`:** loads `semi_next_state` every cycle while in RUN with `global_state` 01 or 10. Otherwise it is held at 01 (waiting).
- **Motion mux, RUN only:**
  - `global_state` 00 selects `manual_move`.
  - 01 selects `semi_move`.
  - 10 selects `auto_move`.
  - Any other case drives 0000.
- **Priority:** `rst` first, then a power toggle, then a mode request.

## Timing
- **Reset values:** `power` 0, `global_state` 00, `semi_state` 01, `moving_state` 0000, `mode_changing` 0, FSM in OFF, all counters 0.
- **Reset mid-operation:** applied on the next edge from any state. It does not wait for SETTLE.
- **Outputs:** all registered. `moving_state` lags its selected input by 1 cycle.
- **Power-on latency:** `power` rises 2 cycles (synchroniser) plus `PWR_MS` ticks after the button is pressed, within one tick period.
- **Mode-change latency:** the change is committed `DEB_MS` + `SETTLE_MS` ticks after `mode_sel` becomes stable.
- **`mode_changing`:** rises on the same edge that the FSM enters SWITCH and falls on the commit edge.
- **Counter widths:**
  - Tick prescaler: clog2(`MS_DIV`) bits; wraps to 0 when the tick fires.
  - Press, debounce and settle counters: 11 bits each, saturating, with no wrap.

## Structure
- **Package `car_pkg`:** mode encodings (`MODE_MANUAL`, `MODE_SEMI`, `MODE_AUTO`), motion codes (`MV_FWD`, `MV_STOP`, `MV_LEFT`, `MV_RIGHT`), semi-auto state codes, and the `OFF`/`RUN`/`SWITCH` state type.
- **Sub-module `ms_tick`:** the prescaler. It is parameterised by `MS_DIV` and outputs a 1-cycle `tick`.

## Test plan
Use `MS_DIV`=10, `PWR_MS`=5, `DEB_MS`=2, `SETTLE_MS`=3 throughout.
- **Power-on:** hold the button for 60 cycles with `mode_sel`=01 → `power`=1 and `global_state`=01. Keep holding → no second toggle. Release, then hold for 60 cycles → `power`=0 and `moving_state`=0000.
- **Mode change:** in RUN with manual mode, `manual_move`=0001; set `mode_sel`=10 → `moving_state`=0000 with `mode_changing`=1 for 3 ticks, then `global_state`=10 and `moving_state` follows `auto_move`.
- **Glitch rejection:** a 1-tick `mode_sel` glitch, or `mode_sel`=11 → no SWITCH entry and `global_state` unchanged.
- **Semi-auto tracking:** in semi-auto RUN, drive `semi_next_state` 00→01→10 → `semi_state` follows 1 cycle later. Switch to manual → `semi_state`=01.
- **Power-off during SWITCH:** a toggle press mid-SWITCH → OFF, `mode_changing`=0, `global_state`=00.
- **Reset mid-SWITCH:** assert `rst` for 1 cycle mid-SWITCH → all outputs at reset values on the next edge.
